// File: rtl/step_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_seq_pkg
// Description : Shared definitions for the step sequencer: controller state
//               encoding, default stage count and the per-stage base duration
//               table (in CP ticks).
// Revision    : 1.0 - initial release
// ============================================================================
package step_seq_pkg;

  // Controller states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_t;

  // Default number of program stages (the stage index is 3 bits wide).
  localparam int C_NUM_STAGES = 5;

  // Base duration table {10, 20, 15, 30, 5}. Indices beyond the table
  // return 0, which the top-level fit check rejects.
  function automatic logic [7:0] base_ticks(input logic [2:0] idx);
    logic [7:0] v;
    case (idx)
      3'd0:    v = 8'd10;
      3'd1:    v = 8'd20;
      3'd2:    v = 8'd15;
      3'd3:    v = 8'd30;
      3'd4:    v = 8'd5;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_sequencer_stage_counter.sv
`default_nettype none
// ============================================================================
// Module      : stage_counter
// Description : Loadable down-counter holding the CP ticks left in the current
//               stage. Load has priority over decrement; the count never
//               wraps below zero. o_is_one flags the last tick of a stage.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_load          - load i_load_val on the next edge
//               i_load_val      - value to load
//               i_en            - decrement by one on the next edge
//               o_count         - current count
//               o_is_one        - count equals one
// Revision    : 1.0 - initial release
// ============================================================================
module stage_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_is_one
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_is_one = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : step_sequencer
// Description : Multi-stage program sequencer. START (in IDLE) launches a
//               program of NUM_STAGES stages; each stage lasts
//               base_ticks(stage) + Sublevel CP ticks, Sublevel being sampled
//               only when a stage is loaded. PAUSE freezes the countdown.
// Ports       : CLK, RST   - clock, synchronous active-high reset
//               CP         - one-cycle tick pulse
//               Sublevel   - 4-bit level added to each stage duration
//               START      - level, starts a program from IDLE
//               PAUSE      - level, freezes the countdown
//               ABORT      - (only with STEP_SEQUENCER_ABORT_EN) return to
//                            IDLE from RUN/HOLD without Done
//               Stage      - current stage index
//               Remain     - CP ticks left in the current stage
//               Busy       - high in RUN or HOLD
//               StageTick  - one-cycle pulse on each stage advance
//               Done       - one-cycle pulse on program completion
// Macro       : STEP_SEQUENCER_ABORT_EN adds the ABORT input.
// Revision    : 1.0 - initial release
// ============================================================================
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int NUM_STAGES = C_NUM_STAGES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CP,
  input  logic [3:0]       Sublevel,
  input  logic             START,
  input  logic             PAUSE,
`ifdef STEP_SEQUENCER_ABORT_EN
  input  logic             ABORT,
`endif
  output logic [2:0]       Stage,
  output logic [CNT_W-1:0] Remain,
  output logic             Busy,
  output logic             StageTick,
  output logic             Done
);

  localparam logic [2:0] c_last_stage = 3'(NUM_STAGES - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [2:0]       r_stage;
  logic [2:0]       w_stage_nxt;
  logic             r_stage_tick;
  logic             w_stage_tick_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_count;
  logic             w_is_one;
  logic             w_abort;

`ifdef STEP_SEQUENCER_ABORT_EN
  assign w_abort = ABORT;
`else
  assign w_abort = 1'b0;
`endif

  // Stage duration, zero-extended to the counter width.
  function automatic logic [CNT_W-1:0] stage_load(input logic [2:0] idx,
                                                  input logic [3:0] sub);
    return CNT_W'(base_ticks(idx)) + CNT_W'(sub);
  endfunction

  stage_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk        (CLK),
    .rst        (RST),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_cnt_en),
    .o_count    (w_count),
    .o_is_one   (w_is_one)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_stage      <= '0;
      r_stage_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_stage      <= w_stage_nxt;
      r_stage_tick <= w_stage_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_stage_nxt      = r_stage;
    w_stage_tick_nxt = 1'b0;
    w_load           = 1'b0;
    w_load_val       = '0;
    w_cnt_en         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_nxt = ST_RUN;
          w_stage_nxt = '0;
          w_load      = 1'b1;
          w_load_val  = stage_load(3'd0, Sublevel);
        end
      end
      ST_RUN: begin
        // PAUSE takes precedence: a CP arriving with it is dropped.
        if (PAUSE) begin
          w_state_nxt = ST_HOLD;
        end else if (CP) begin
          if (!w_is_one) begin
            w_cnt_en = 1'b1;
          end else if (r_stage == c_last_stage) begin
            w_state_nxt = ST_FINISH;
            w_load      = 1'b1;
            w_load_val  = '0;
          end else begin
            w_stage_nxt      = r_stage + 3'd1;
            w_load           = 1'b1;
            w_load_val       = stage_load(r_stage + 3'd1, Sublevel);
            w_stage_tick_nxt = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!PAUSE) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FINISH: begin
        // START is not sampled here, so a held START restarts via IDLE.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Abort overrides every RUN/HOLD decision above.
    if (w_abort && ((r_state == ST_RUN) || (r_state == ST_HOLD))) begin
      w_state_nxt      = ST_IDLE;
      w_stage_nxt      = '0;
      w_stage_tick_nxt = 1'b0;
      w_load           = 1'b1;
      w_load_val       = '0;
      w_cnt_en         = 1'b0;
    end
  end

  assign Stage     = r_stage;
  assign Remain    = w_count;
  assign Busy      = (r_state == ST_RUN) || (r_state == ST_HOLD);
  assign StageTick = r_stage_tick;
  assign Done      = (r_state == ST_FINISH);

  // Every stage duration must be non-zero and survive the largest Sublevel
  // without overflowing the counter.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_base_fit
      always_ff @(posedge CLK) begin
        a_base_fits: assert ((base_ticks(3'(gi)) != 8'd0) &&
                             ((64'(base_ticks(3'(gi))) + 64'd15) < (64'd1 << CNT_W)));
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_sequencer
// Description : Self-checking bench for step_sequencer. Expected StageTick and
//               Done events are queued when a program is launched and popped
//               by a monitor when the DUT pulses; direct checks cover reset,
//               loads, pause, restart and (with STEP_SEQUENCER_ABORT_EN) abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_sequencer;

  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             CP;
  logic [3:0]       Sublevel;
  logic             START;
  logic             PAUSE;
`ifdef STEP_SEQUENCER_ABORT_EN
  logic             ABORT;
`endif
  logic [2:0]       Stage;
  logic [CNT_W-1:0] Remain;
  logic             Busy;
  logic             StageTick;
  logic             Done;

  step_sequencer #(
    .CNT_W      (CNT_W),
    .NUM_STAGES (5)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CP        (CP),
    .Sublevel  (Sublevel),
    .START     (START),
    .PAUSE     (PAUSE),
`ifdef STEP_SEQUENCER_ABORT_EN
    .ABORT     (ABORT),
`endif
    .Stage     (Stage),
    .Remain    (Remain),
    .Busy      (Busy),
    .StageTick (StageTick),
    .Done      (Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int stage;
    int remain;
    int cps;
  } ev_t;

  ev_t q_tick[$];
  ev_t q_done[$];
  int  c_base[5] = '{10, 20, 15, 30, 5};
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_cp  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One CP pulse followed by three quiet cycles. Only CPs issued with PAUSE
  // low can be counted by the DUT.
  task automatic send_cp();
    CP = 1'b1;
    if (!PAUSE) n_cp++;
    tick();
    CP = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // Queue the StageTick events (and optionally Done) of one program.
  task automatic push_prog(input int sub0, input int subr, input int n_ticks, input bit with_done);
    int cps;
    cps = c_base[0] + sub0;
    for (int i = 1; i <= n_ticks; i++) begin
      q_tick.push_back('{i, c_base[i] + subr, cps});
      cps += c_base[i] + subr;
    end
    if (with_done) q_done.push_back('{4, 0, cps});
  endtask

  task automatic start_pulse();
    n_cp  = 0;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic chk_queues_empty(input string tag);
    chk({tag, "_tick_q_left"}, q_tick.size(), 0);
    chk({tag, "_done_q_left"}, q_done.size(), 0);
  endtask

  always @(negedge CLK) begin : mon
    ev_t e;
    if (StageTick === 1'b1) begin
      if (q_tick.size() == 0) begin
        chk("unexpected_stagetick", StageTick, 0);
      end else begin
        e = q_tick.pop_front();
        chk("tick_stage", Stage, e.stage);
        chk("tick_remain", Remain, e.remain);
        chk("tick_cp_count", n_cp, e.cps);
      end
    end
    if (Done === 1'b1) begin
      if (q_done.size() == 0) begin
        chk("unexpected_done", Done, 0);
      end else begin
        e = q_done.pop_front();
        chk("done_stage", Stage, e.stage);
        chk("done_remain", Remain, e.remain);
        chk("done_cp_count", n_cp, e.cps);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RST      = 1'b1;
    CP       = 1'b0;
    Sublevel = 4'd0;
    START    = 1'b0;
    PAUSE    = 1'b0;
`ifdef STEP_SEQUENCER_ABORT_EN
    ABORT    = 1'b0;
`endif
    tick();
    tick();
    chk("rst_stage", Stage, 0);
    chk("rst_remain", Remain, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_stagetick", StageTick, 0);
    chk("rst_done", Done, 0);
    RST = 1'b0;
    tick();

    // Full program, Sublevel 0, CP every 4 clocks.
    push_prog(0, 0, 4, 1'b1);
    start_pulse();
    chk("t1_busy", Busy, 1);
    chk("t1_stage", Stage, 0);
    chk("t1_remain", Remain, 10);
    send_cp();
    chk("t1_decrement", Remain, 9);
    repeat (79) send_cp();
    tick();
    chk("t1_idle_busy", Busy, 0);
    chk("t1_hold_stage", Stage, 4);
    chk("t1_hold_remain", Remain, 0);
    chk_queues_empty("t1");

    // Sublevel sampled only at stage load; START while running ignored.
    Sublevel = 4'd3;
    push_prog(3, 9, 4, 1'b1);
    start_pulse();
    chk("t2_remain", Remain, 13);
    repeat (5) send_cp();
    Sublevel = 4'd9;
    chk("t2_remain_kept", Remain, 8);
    repeat (8) send_cp();
    chk("t2_stage1", Stage, 1);
    chk("t2_stage1_load", Remain, 29);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("t2_start_ignored_stage", Stage, 1);
    chk("t2_start_ignored_remain", Remain, 29);
    repeat (106) send_cp();
    tick();
    chk("t2_idle_busy", Busy, 0);
    chk_queues_empty("t2");
    Sublevel = 4'd0;

    // PAUSE for 50 clocks during stage 2 with CPs arriving.
    push_prog(0, 0, 4, 1'b1);
    start_pulse();
    repeat (33) send_cp();
    chk("t3_stage", Stage, 2);
    chk("t3_remain", Remain, 12);
    PAUSE = 1'b1;
    CP    = 1'b1;
    tick();
    CP = 1'b0;
    chk("t3_pause_cp_dropped", Remain, 12);
    chk("t3_hold_busy", Busy, 1);
    for (int i = 0; i < 49; i++) begin
      CP = ((i % 4) == 3);
      tick();
      if ((i % 4) == 3) chk("t3_frozen", Remain, 12);
    end
    CP    = 1'b0;
    PAUSE = 1'b0;
    tick();
    chk("t3_resume_remain", Remain, 12);
    tick();
    tick();
    repeat (47) send_cp();
    tick();
    chk("t3_idle_busy", Busy, 0);
    chk_queues_empty("t3");

    // Reset in the middle of stage 3.
    push_prog(0, 0, 3, 1'b0);
    start_pulse();
    repeat (68) send_cp();
    chk("t4_stage", Stage, 3);
    chk("t4_remain", Remain, 7);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t4_rst_stage", Stage, 0);
    chk("t4_rst_remain", Remain, 0);
    chk("t4_rst_busy", Busy, 0);
    chk("t4_rst_stagetick", StageTick, 0);
    chk("t4_rst_done", Done, 0);
    repeat (3) send_cp();
    chk("t4_idle_remain", Remain, 0);
    chk("t4_idle_busy", Busy, 0);
    chk_queues_empty("t4");

    // START held high: Done, one IDLE cycle, then restart.
    push_prog(0, 0, 4, 1'b1);
    n_cp  = 0;
    START = 1'b1;
    tick();
    repeat (79) send_cp();
    CP = 1'b1;
    n_cp++;
    tick();
    CP = 1'b0;
    chk("t5_done", Done, 1);
    chk("t5_finish_busy", Busy, 0);
    tick();
    chk("t5_idle_done", Done, 0);
    chk("t5_idle_busy", Busy, 0);
    chk("t5_idle_stage", Stage, 4);
    chk("t5_idle_remain", Remain, 0);
    tick();
    chk("t5_restart_busy", Busy, 1);
    chk("t5_restart_stage", Stage, 0);
    chk("t5_restart_remain", Remain, 10);
    START = 1'b0;
    RST   = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    chk_queues_empty("t5");

`ifdef STEP_SEQUENCER_ABORT_EN
    // Abort on the last tick of stage 1, coincident with CP.
    push_prog(0, 0, 1, 1'b0);
    start_pulse();
    repeat (29) send_cp();
    chk("t6_stage", Stage, 1);
    chk("t6_remain", Remain, 1);
    ABORT = 1'b1;
    CP    = 1'b1;
    tick();
    ABORT = 1'b0;
    CP    = 1'b0;
    chk("t6_abort_busy", Busy, 0);
    chk("t6_abort_stage", Stage, 0);
    chk("t6_abort_remain", Remain, 0);
    chk("t6_abort_stagetick", StageTick, 0);
    chk("t6_abort_done", Done, 0);
    tick();
    tick();
    chk_queues_empty("t6");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
